sipo_deser: RTL and testbench
=============================

// Module: sipo_deser
// PURPOSE
//   Serial-in/parallel-out deserializer. It receives the LSB-first bit stream that the
//   shift-register transmitters produce (bit 0 first, one bit per strobe) and rebuilds
//   N-bit words. Sits at the receive end of the serial link and hands words on through a
//   valid/ready holding register. Flags overrun and framing errors.
// PARAMETERS
//   N       4   word width in bits; legal values are N >= 2
//   CNT_W   $clog2(N+1)   bit-counter width; derived, do not override
// PORTS
//   clk           in   1   single clock; all state updates on posedge
//   reset         in   1   synchronous, active-high; sampled on posedge clk
//   serial_in     in   1   serial data; sampled only when bit_en=1
//   bit_en        in   1   bit strobe; one data bit per cycle where bit_en=1
//   frame_sync    in   1   qualified by bit_en; marks the current bit as bit 0 of a word
//   parallel_out  out  N   received word; stable while out_valid=1
//   out_valid     out  1   holding register is full
//   out_ready     in   1   consumer accepts the word when out_valid & out_ready
//   overrun       out  1   sticky: a completed word was dropped
//   frame_err     out  1   sticky: frame_sync arrived mid-word
//   clear_err     in   1   clears overrun and frame_err
// BEHAVIOUR
//   Reset: state=IDLE, shift_reg=0, cnt=0, parallel_out=0, out_valid=0, overrun=0, frame_err=0.
//   FSM states:
//     IDLE : on bit_en & frame_sync -> shift_reg={serial_in, shift_reg[N-1:1]}, cnt=1, go to SHIFT.
//            bit_en without frame_sync is ignored.
//     SHIFT: on bit_en & ~frame_sync -> shift right, new bit enters the MSB, cnt++.
//            on bit_en & frame_sync  -> resync: discard the partial word, treat this bit as bit 0,
//                                       cnt=1, frame_err<=1.
//            on the Nth bit (cnt==N-1 & bit_en & ~frame_sync) -> word complete, cnt=0, go to IDLE.
//   Bit order: after N strobes, the first received bit is at parallel_out[0]. This is the exact
//     inverse of a right-shifting transmitter that drives serial_out = reg[0].
//   Completion and hand-off, in the cycle the Nth bit is sampled:
//     - holding register empty, or (out_valid & out_ready): load the word; out_valid=1 from the
//       next cycle. Latency is 1 clk from the Nth bit_en to out_valid.
//     - holding register full and out_ready=0: drop the new word, overrun<=1, holding register unchanged.
//   Handshake: parallel_out and out_valid hold until out_valid & out_ready.
//     The cycle after acceptance, out_valid=0, unless a new word loaded in that same cycle.
//   Back-to-back: frame_sync is legal on the bit_en immediately after the Nth bit, with zero idle bits.
//   Stall: bit_en=0 for any number of cycles freezes shift_reg and cnt, with no timeout.
//   Errors: sticky until clear_err. If clear_err coincides with a new error event, the event wins (flag stays 1).
//   Reset mid-word or mid-handshake: the partial word and the held word are lost; all outputs
//     return to their reset values on the next posedge.
//   Not supported: changing N at runtime, and bit_en faster than one bit per clk.
// STRUCTURE
//   Shared package/header sipo_pkg: state localparams ST_IDLE=1'b0 and ST_SHIFT=1'b1, plus the
//     CNT_W derivation, reused by the matching transmitter bench.
//   One sub-module: sipo_hold_reg. It is an N-bit valid/ready holding register with load,
//     accept and drop indication.
//   Top level contains the FSM, the shift register, the bit counter and the error flags.
// TESTING (N=4)
//   1. Send the stream 1,0,1,1 starting with frame_sync, bit_en every cycle, out_ready=1
//      -> parallel_out=4'b1101 with out_valid=1 one clk after the 4th bit; overrun=0.
//   2. Send two back-to-back words A then 5 with out_ready=0
//      -> parallel_out=A held, the second word is dropped, overrun=1.
//      Then assert clear_err -> overrun=0.
//   3. Send frame_sync on the 3rd bit of a word, followed by 0,1,1,0
//      -> frame_err=1 and parallel_out=4'b0110; the partial word is never output.
//   4. Send word C with bit_en=1 only every 3rd cycle -> identical result to continuous bit_en;
//      out_valid 1 clk after the last strobe.
//   5. Assert reset after 2 bits, then send a clean frame of 9
//      -> no output from the partial word, then parallel_out=4'h9.
//   6. Loopback with the existing 4-bit PISO transmitter and random words (1000 iterations)
//      -> every parallel_out equals the parallel_in that was loaded.

Source files
------------

// File: rtl/sipo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sipo_pkg
// Description : Shared constants for the serial link receive path. It holds
//               the FSM state encodings and the bit-counter width derivation.
//               The matching transmitter bench reuses both.
// Revision    : 1.0 - initial release
// ============================================================================
package sipo_pkg;

    // FSM state encodings
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // The bit counter has to represent 0..n, so it needs $clog2(n+1) bits.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage : sipo_pkg
`default_nettype wire

// File: rtl/sipo_hold_reg.sv
`default_nettype none
// ============================================================================
// Module      : sipo_hold_reg
// Description : N-bit valid/ready holding register. A load request is taken
//               when the register is empty, or when its current word is
//               accepted in the same cycle. Any other load request is
//               dropped, and o_dropped reports it.
// Ports       : clk, rst      - clock and synchronous active-high reset
//               i_load        - a completed word is offered this cycle
//               i_data [N]    - the offered word
//               i_ready       - consumer accepts when o_valid & i_ready
//               o_data [N]    - held word, stable while o_valid=1
//               o_valid       - register full
//               o_dropped     - the offered word could not be stored
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_hold_reg #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [N-1:0] i_data,
    input  logic         i_ready,
    output logic [N-1:0] o_data,
    output logic         o_valid,
    output logic         o_dropped
);

    logic [N-1:0] r_data;
    logic         r_valid;
    logic         w_accept;
    logic         w_can_load;

    assign w_accept   = r_valid & i_ready;
    // A slot is free in this cycle if the register is empty, or if the
    // register drains in this same cycle.
    assign w_can_load = ~r_valid | w_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load && w_can_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (w_accept) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_dropped = i_load & ~w_can_load;

endmodule : sipo_hold_reg
`default_nettype wire

// File: rtl/sipo_deser.sv
`default_nettype none
// ============================================================================
// Module      : sipo_deser
// Description : Serial-in/parallel-out deserializer for an LSB-first link.
//               frame_sync marks bit 0 of a word. Each bit_en strobe shifts
//               in one bit. A finished word goes to a valid/ready holding
//               register. Sticky flags report dropped words and frame
//               re-synchronisation.
// Ports       : clk, reset    - clock and synchronous active-high reset
//               serial_in     - serial data, sampled only with bit_en
//               bit_en        - one data bit per strobe
//               frame_sync    - qualified by bit_en, current bit is bit 0
//               parallel_out  - received word, stable while out_valid=1
//               out_valid     - holding register full
//               out_ready     - consumer accepts on out_valid & out_ready
//               overrun       - sticky, a completed word was dropped
//               frame_err     - sticky, frame_sync arrived mid-word
//               clear_err     - clears both sticky flags
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = cnt_width(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         serial_in,
    input  logic         bit_en,
    input  logic         frame_sync,
    output logic [N-1:0] parallel_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         overrun,
    output logic         frame_err,
    input  logic         clear_err
);

    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(N - 1);

    logic [0:0]   r_state;
    logic [0:0]   w_state_next;
    logic [N-1:0] r_shift;
    logic [N-1:0] w_shift_next;
    logic [CNT_W-1:0] r_cnt;
    logic         r_overrun;
    logic         r_frame_err;

    // FSM output strobes
    logic         w_capture;    // shift serial_in into the register
    logic         w_restart;    // this bit is bit 0 of a new word
    logic         w_advance;    // ordinary mid-word bit
    logic         w_word_done;  // Nth bit of a word
    logic         w_resync;     // frame_sync seen mid-word

    logic         w_dropped;

    // The new bit enters at the MSB. After N strobes the first bit is at
    // bit 0. This undoes a right-shifting transmitter that drives reg[0].
    assign w_shift_next = {serial_in, r_shift[N-1:1]};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bit_en && frame_sync) begin
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_en && !frame_sync && (r_cnt == c_cnt_last)) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_capture   = 1'b0;
        w_restart   = 1'b0;
        w_advance   = 1'b0;
        w_word_done = 1'b0;
        w_resync    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A strobe without frame_sync carries no word position, so
                // the receiver ignores it.
                if (bit_en && frame_sync) begin
                    w_capture = 1'b1;
                    w_restart = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (bit_en) begin
                    w_capture = 1'b1;
                    if (frame_sync) begin
                        // The stale partial bits need no clearing. They
                        // shift out before the new word completes.
                        w_restart = 1'b1;
                        w_resync  = 1'b1;
                    end else if (r_cnt == c_cnt_last) begin
                        w_word_done = 1'b1;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Shift register and bit counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift <= '0;
        end else if (w_capture) begin
            r_shift <= w_shift_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_restart) begin
            r_cnt <= c_cnt_one;
        end else if (w_word_done) begin
            r_cnt <= '0;
        end else if (w_advance) begin
            r_cnt <= r_cnt + c_cnt_one;
        end
    end

    // ------------------------------------------------------------------
    // Output holding register. It is loaded with the completed word,
    // including the bit being sampled now.
    // ------------------------------------------------------------------
    sipo_hold_reg #(
        .N (N)
    ) u_hold (
        .clk       (clk),
        .rst       (reset),
        .i_load    (w_word_done),
        .i_data    (w_shift_next),
        .i_ready   (out_ready),
        .o_data    (parallel_out),
        .o_valid   (out_valid),
        .o_dropped (w_dropped)
    );

    // ------------------------------------------------------------------
    // Sticky error flags. A new event takes priority over clear_err, so
    // no error is lost when the two coincide.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_dropped) begin
            r_overrun <= 1'b1;
        end else if (clear_err) begin
            r_overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_err <= 1'b0;
        end else if (w_resync) begin
            r_frame_err <= 1'b1;
        end else if (clear_err) begin
            r_frame_err <= 1'b0;
        end
    end

    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;

endmodule : sipo_deser
`default_nettype wire

// File: tb/tb_sipo_deser.sv
`default_nettype none
// ============================================================================
// Module      : tb_sipo_deser
// Description : Self-checking bench for sipo_deser with N=4. Each expected
//               word is queued when its bits are driven. The word is compared
//               when the DUT presents it with out_valid & out_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo_deser;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         serial_in;
    logic         bit_en;
    logic         frame_sync;
    logic [N-1:0] parallel_out;
    logic         out_valid;
    logic         out_ready;
    logic         overrun;
    logic         frame_err;
    logic         clear_err;

    int           errors = 0;
    int           checks = 0;
    logic [N-1:0] exp_q[$];
    logic [N-1:0] sb_exp;

    always #5 clk = ~clk;

    sipo_deser #(.N(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .serial_in    (serial_in),
        .bit_en       (bit_en),
        .frame_sync   (frame_sync),
        .parallel_out (parallel_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overrun      (overrun),
        .frame_err    (frame_err),
        .clear_err    (clear_err)
    );

    // One clock cycle. At the negedge, any word handed over this cycle is
    // taken off the scoreboard and compared. The task then returns 1ns
    // after the posedge, so callers can check the registered results.
    task automatic cycle();
        @(negedge clk);
        if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_unexpected: got word %h, required no word", parallel_out);
            end else begin
                sb_exp = exp_q.pop_front();
                if (parallel_out !== sb_exp) begin
                    errors++;
                    $display("FAIL scoreboard_word: got %h, required %h", parallel_out, sb_exp);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic en, input logic fs);
        serial_in  = b;
        bit_en     = en;
        frame_sync = fs;
        cycle();
    endtask

    task automatic test_reset();
        reset = 1'b1; serial_in = 1'b0; bit_en = 1'b0; frame_sync = 1'b0;
        out_ready = 1'b0; clear_err = 1'b0;
        cycle(); cycle();
        checks += 4;
        if (out_valid !== 1'b0)    begin errors++; $display("FAIL reset_valid: got %b, required 0", out_valid); end
        if (parallel_out !== '0)   begin errors++; $display("FAIL reset_data: got %h, required 0", parallel_out); end
        if (overrun !== 1'b0)      begin errors++; $display("FAIL reset_overrun: got %b, required 0", overrun); end
        if (frame_err !== 1'b0)    begin errors++; $display("FAIL reset_frame_err: got %b, required 0", frame_err); end
        reset = 1'b0;
        cycle();
    endtask

    // Stream 1,0,1,1 gives 4'b1101 one clock after the 4th strobe.
    task automatic test_basic();
        logic [N-1:0] w;
        w = 4'b1101;
        out_ready = 1'b1;
        exp_q.push_back(w);
        for (int i = 0; i < N; i++) begin
            if (i == N - 1) begin
                checks++;
                if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b, required 0", out_valid); end
            end
            send_bit(w[i], 1'b1, i == 0);
        end
        checks += 3;
        if (out_valid !== 1'b1)  begin errors++; $display("FAIL basic_latency: got out_valid %b, required 1", out_valid); end
        if (parallel_out !== w)  begin errors++; $display("FAIL basic_data: got %h, required %h", parallel_out, w); end
        if (overrun !== 1'b0)    begin errors++; $display("FAIL basic_overrun: got %b, required 0", overrun); end
        bit_en = 1'b0;
        cycle();
    endtask

    // Two back-to-back words while the consumer stalls: the second is dropped.
    task automatic test_overrun();
        logic [N-1:0] wa, wb;
        wa = 4'hA; wb = 4'h5;
        out_ready = 1'b0;
        exp_q.push_back(wa);
        for (int i = 0; i < N; i++) send_bit(wa[i], 1'b1, i == 0);
        for (int i = 0; i < N; i++) send_bit(wb[i], 1'b1, i == 0);
        checks += 3;
        if (out_valid !== 1'b1)   begin errors++; $display("FAIL overrun_valid: got %b, required 1", out_valid); end
        if (parallel_out !== wa)  begin errors++; $display("FAIL overrun_held: got %h, required %h", parallel_out, wa); end
        if (overrun !== 1'b1)     begin errors++; $display("FAIL overrun_flag: got %b, required 1", overrun); end
        bit_en = 1'b0;
        clear_err = 1'b1;
        cycle();
        clear_err = 1'b0;
        checks += 2;
        if (overrun !== 1'b0)     begin errors++; $display("FAIL overrun_clear: got %b, required 0", overrun); end
        if (parallel_out !== wa)  begin errors++; $display("FAIL overrun_hold_after_clear: got %h, required %h", parallel_out, wa); end
        out_ready = 1'b1;
        cycle();
        checks++;
        if (out_valid !== 1'b0)   begin errors++; $display("FAIL overrun_drain: got out_valid %b, required 0", out_valid); end
    endtask

    // frame_sync arrives on the 3rd bit and restarts the word. Then 0,1,1,0 follows.
    task automatic test_resync();
        logic [N-1:0] w;
        w = 4'b0110;
        out_ready = 1'b1;
        exp_q.push_back(w);
        send_bit(1'b1, 1'b1, 1'b1);
        send_bit(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < N; i++) send_bit(w[i], 1'b1, i == 0);
        checks += 3;
        if (frame_err !== 1'b1)  begin errors++; $display("FAIL resync_flag: got %b, required 1", frame_err); end
        if (out_valid !== 1'b1)  begin errors++; $display("FAIL resync_valid: got %b, required 1", out_valid); end
        if (parallel_out !== w)  begin errors++; $display("FAIL resync_data: got %h, required %h", parallel_out, w); end
        bit_en = 1'b0;
        clear_err = 1'b1;
        cycle();
        clear_err = 1'b0;
        checks++;
        if (frame_err !== 1'b0)  begin errors++; $display("FAIL resync_clear: got %b, required 0", frame_err); end
    endtask

    // A strobe every 3rd cycle. The idle cycles carry random data and sync.
    task automatic test_stall();
        logic [N-1:0] w;
        w = 4'hC;
        out_ready = 1'b1;
        exp_q.push_back(w);
        for (int i = 0; i < N; i++) begin
            if (i == N - 1) begin
                checks++;
                if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_early_valid: got %b, required 0", out_valid); end
            end
            send_bit(w[i], 1'b1, i == 0);
            if (i == N - 1) begin
                checks += 2;
                if (out_valid !== 1'b1)  begin errors++; $display("FAIL stall_latency: got out_valid %b, required 1", out_valid); end
                if (parallel_out !== w)  begin errors++; $display("FAIL stall_data: got %h, required %h", parallel_out, w); end
            end else begin
                send_bit(1'($urandom), 1'b0, 1'($urandom));
                send_bit(1'($urandom), 1'b0, 1'($urandom));
            end
        end
        bit_en = 1'b0; frame_sync = 1'b0;
        cycle();
    endtask

    // Reset while a word is held and another is partly received.
    task automatic test_mid_reset();
        logic [N-1:0] wh, w9;
        wh = 4'h3; w9 = 4'h9;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) send_bit(wh[i], 1'b1, i == 0);
        send_bit(1'b1, 1'b1, 1'b1);
        send_bit(1'b0, 1'b1, 1'b0);
        bit_en = 1'b0; frame_sync = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        checks += 2;
        if (out_valid !== 1'b0)   begin errors++; $display("FAIL midreset_valid: got %b, required 0", out_valid); end
        if (parallel_out !== '0)  begin errors++; $display("FAIL midreset_data: got %h, required 0", parallel_out); end
        out_ready = 1'b1;
        exp_q.push_back(w9);
        for (int i = 0; i < N; i++) send_bit(w9[i], 1'b1, i == 0);
        checks += 2;
        if (out_valid !== 1'b1)   begin errors++; $display("FAIL midreset_new_valid: got %b, required 1", out_valid); end
        if (parallel_out !== w9)  begin errors++; $display("FAIL midreset_new_data: got %h, required %h", parallel_out, w9); end
        bit_en = 1'b0;
        cycle();
    endtask

    // Loopback from a right-shifting PISO model. It drives serial_out =
    // reg[0], with random idle gaps and back-to-back frames.
    task automatic test_loopback();
        logic [N-1:0] tx_reg;
        logic [N-1:0] word;
        out_ready = 1'b1;
        for (int it = 0; it < 1000; it++) begin
            word = N'($urandom);
            exp_q.push_back(word);
            tx_reg = word;
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 3) == 0) send_bit(1'($urandom), 1'b0, 1'b0);
                send_bit(tx_reg[0], 1'b1, b == 0);
                tx_reg = tx_reg >> 1;
            end
        end
        bit_en = 1'b0;
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) cycle();
        checks += 2;
        if (exp_q.size() != 0) begin errors++; $display("FAIL loopback_drain: %0d words outstanding, required 0", exp_q.size()); end
        if (overrun !== 1'b0)  begin errors++; $display("FAIL loopback_overrun: got %b, required 0", overrun); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_resync();
        test_stall();
        test_mid_reset();
        test_loopback();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sipo_deser
`default_nettype wire
